// File: rtl/lsu_sequencer.sv
// Multi-cycle load/store sequencer between core control and a req/gnt/rvalid data bus.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word accesses retire with a misalign strobe, no bus traffic.
module lsu_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] rdata_out,
  output logic        wb_en,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        func3_q, func3_d;
  logic              isLoad_q, isLoad_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              misIn;
  logic              timeoutHit;
  logic              reqActive;
  logic              inReq;
  logic [3:0]        beCalc;
  logic [31:0]       wdataRep;
  logic [7:0]        laneByte;
  logic [15:0]       laneHalf;
  logic [31:0]       loadExt;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misIn = ((func3[1:0] == 2'b01) && addr[0]) || (func3[1] && (addr[1:0] != 2'b00));
`else
  assign misIn = 1'b0;
`endif

  assign timeoutHit = (TIMEOUT != 0) && (cnt_q == TimeoutCnt);

  // Lane generation and load extraction always work from the captured access.
  always_comb begin
    beCalc   = 4'b1111;
    wdataRep = wdata_q;
    case (func3_q[1:0])
      2'b00: begin
        beCalc   = 4'b0001 << addr_q[1:0];
        wdataRep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        beCalc   = 4'b0011 << {addr_q[1], 1'b0};
        wdataRep = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase

    case (addr_q[1:0])
      2'd0:    laneByte = bus_rdata[7:0];
      2'd1:    laneByte = bus_rdata[15:8];
      2'd2:    laneByte = bus_rdata[23:16];
      default: laneByte = bus_rdata[31:24];
    endcase
    laneHalf = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (func3_q)
      3'b000:  loadExt = {{24{laneByte[7]}}, laneByte};
      3'b001:  loadExt = {{16{laneHalf[15]}}, laneHalf};
      3'b100:  loadExt = {24'h0, laneByte};
      3'b101:  loadExt = {16'h0, laneHalf};
      default: loadExt = bus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    func3_d   = func3_q;
    isLoad_d  = isLoad_q;
    err_d     = err_q;
    mis_d     = mis_q;
    cnt_d     = cnt_q;
    reqActive = 1'b0;
    stall     = 1'b0;

    case (state_q)
      IDLE: begin
        stall = load | store;
        if (load | store) begin
          addr_d   = addr;
          func3_d  = func3;
          wdata_d  = wdata;
          isLoad_d = load;
          err_d    = 1'b0;
          mis_d    = misIn;
          cnt_d    = '0;
          state_d  = misIn ? DONE : REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (timeoutHit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          reqActive = 1'b1;
          if (bus_gnt) state_d = isLoad_q ? WAIT : DONE;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (timeoutHit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus_rvalid) begin
          rdata_d = loadExt;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      func3_q  <= '0;
      isLoad_q <= 1'b0;
      err_q    <= 1'b0;
      mis_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      func3_q  <= func3_d;
      isLoad_q <= isLoad_d;
      err_q    <= err_d;
      mis_q    <= mis_d;
      cnt_q    <= cnt_d;
    end
  end

  // Bus attributes are only driven while a request is being presented.
  assign inReq     = (state_q == REQ);
  assign bus_req   = reqActive;
  assign bus_we    = inReq & ~isLoad_q;
  assign bus_addr  = inReq ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be    = inReq ? beCalc : 4'b0000;
  assign bus_wdata = inReq ? wdataRep : 32'h0;
  assign rdata_out = rdata_q;
  assign wb_en     = (state_q == DONE) & isLoad_q & ~err_q & ~mis_q;
  assign bus_err   = (state_q == DONE) & err_q;
  assign misalign  = (state_q == DONE) & mis_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: a table of single accesses plus hand-written
// sequences for delayed grant, timeouts, reset mid-access and misaligned access.
module tb_lsu_sequencer;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0]  be;
    logic [31:0] bwd;
    logic [31:0] rout;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [2:0]  func3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        stall;
  logic [31:0] rdata_out;
  logic        wb_en;
  logic        bus_err;
  logic        misalign;

  int          checks;
  int          errors;
  logic [31:0] lastRd;
  vec_t        vecs [12];

  lsu_sequencer #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .func3(func3),
    .addr(addr), .wdata(wdata), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .stall(stall), .rdata_out(rdata_out), .wb_en(wb_en),
    .bus_err(bus_err), .misalign(misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic gnt, input logic rv, input logic [31:0] rd);
    load       = ld;
    store      = st;
    func3      = f3;
    addr       = a;
    wdata      = wd;
    bus_gnt    = gnt;
    bus_rvalid = rv;
    bus_rdata  = rd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // One access with grant and rvalid available immediately.
  task automatic runVector(input vec_t v);
    logic isLd;
    isLd = v.ld;
    applyStimulus(v.ld, v.st, v.f3, v.addr, v.wd, 1'b1, 1'b1, v.rd);
    #1;
    checkOutput("idle_stall", {31'b0, stall}, 32'd1);
    step();
    checkOutput("req_bus_req", {31'b0, bus_req}, 32'd1);
    checkOutput("req_stall", {31'b0, stall}, 32'd1);
    checkOutput("req_addr", bus_addr, {v.addr[31:2], 2'b00});
    checkOutput("req_be", {28'b0, bus_be}, {28'b0, v.be});
    checkOutput("req_we", {31'b0, bus_we}, {31'b0, ~isLd});
    if (!isLd) checkOutput("req_wdata", bus_wdata, v.bwd);
    step();
    if (isLd) begin
      checkOutput("wait_bus_req", {31'b0, bus_req}, 32'd0);
      checkOutput("wait_stall", {31'b0, stall}, 32'd1);
      checkOutput("wait_wb_en", {31'b0, wb_en}, 32'd0);
      step();
      lastRd = v.rout;
    end
    checkOutput("done_stall", {31'b0, stall}, 32'd0);
    checkOutput("done_wb_en", {31'b0, wb_en}, {31'b0, isLd});
    checkOutput("done_rdata", rdata_out, lastRd);
    checkOutput("done_bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("done_misalign", {31'b0, misalign}, 32'd0);
    checkOutput("done_bus_req", {31'b0, bus_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("idle_wb_en", {31'b0, wb_en}, 32'd0);
    checkOutput("idle_stall_off", {31'b0, stall}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    lastRd = 32'h0;
    rst    = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h1000_0008, 32'h0,         32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_8000, 4'b0010, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_8000, 4'b0010, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_0000, 4'b1100, 32'h0,         32'hFFFF_8001};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'h8001_0000, 4'b1100, 32'h0,         32'h0000_8001};
    vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h7F00_0000, 4'b1000, 32'h0,         32'h0000_007F};
    vecs[6]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0204, 32'h0,         32'hCAFE_F00D, 4'b1111, 32'h0,         32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 32'h0,         4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h1234_BEEF, 32'h0,         4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 3'b010, 32'h0000_030C, 32'h0123_4567, 32'h0,         4'b1111, 32'h0123_4567, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0000_0400, 32'h9999_9999, 32'h0000_55AA, 4'b1111, 32'h0,         32'h0000_55AA};
    vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h0000_F00F, 4'b0011, 32'h0,         32'hFFFF_F00F};

    #12;
    checkOutput("rst_bus_req", {31'b0, bus_req}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_wb_en", {31'b0, wb_en}, 32'd0);
    checkOutput("rst_rdata", rdata_out, 32'h0);
    checkOutput("rst_bus_be", {28'b0, bus_be}, 32'h0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_bus_we", {31'b0, bus_we}, 32'd0);
    checkOutput("rst_bus_err", {31'b0, bus_err}, 32'd0);
    checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) runVector(vecs[i]);

    // Store with grant arriving in the fourth request cycle.
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0203, 32'h0000_00A5, 1'b0, 1'b0, 32'h0);
    step();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) bus_gnt = 1'b1;
      checkOutput("sb_hold_req", {31'b0, bus_req}, 32'd1);
      checkOutput("sb_hold_be", {28'b0, bus_be}, 32'h8);
      checkOutput("sb_hold_wdata", bus_wdata, 32'hA5A5_A5A5);
      checkOutput("sb_hold_addr", bus_addr, 32'h0000_0200);
      checkOutput("sb_hold_we", {31'b0, bus_we}, 32'd1);
      step();
    end
    checkOutput("sb_done_stall", {31'b0, stall}, 32'd0);
    checkOutput("sb_done_wb_en", {31'b0, wb_en}, 32'd0);
    checkOutput("sb_done_req", {31'b0, bus_req}, 32'd0);
    checkOutput("sb_done_err", {31'b0, bus_err}, 32'd0);
    applyStimulus(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();

    // Timeout while waiting for grant.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0600, 32'h0, 1'b0, 1'b0, 32'h1234_5678);
    step();
    for (int k = 1; k <= 4; k++) begin
      checkOutput("to_req_held", {31'b0, bus_req}, 32'd1);
      step();
    end
    checkOutput("to_req_drop", {31'b0, bus_req}, 32'd0);
    checkOutput("to_req_stall", {31'b0, stall}, 32'd1);
    checkOutput("to_req_err_early", {31'b0, bus_err}, 32'd0);
    step();
    checkOutput("to_done_err", {31'b0, bus_err}, 32'd1);
    checkOutput("to_done_wb_en", {31'b0, wb_en}, 32'd0);
    checkOutput("to_done_stall", {31'b0, stall}, 32'd0);
    checkOutput("to_done_rdata", rdata_out, lastRd);
    applyStimulus(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("to_idle_err", {31'b0, bus_err}, 32'd0);

    // Timeout while waiting for read data.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0700, 32'h0, 1'b1, 1'b0, 32'h1357_9BDF);
    step();
    checkOutput("tow_req", {31'b0, bus_req}, 32'd1);
    bus_gnt = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checkOutput("tow_wait_stall", {31'b0, stall}, 32'd1);
      checkOutput("tow_wait_err", {31'b0, bus_err}, 32'd0);
    end
    step();
    checkOutput("tow_done_err", {31'b0, bus_err}, 32'd1);
    checkOutput("tow_done_wb_en", {31'b0, wb_en}, 32'd0);
    checkOutput("tow_done_rdata", rdata_out, lastRd);
    applyStimulus(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();

    // Reset asserted in WAIT, then a stray rvalid.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    checkOutput("rw_wait_stall", {31'b0, stall}, 32'd1);
    #2;
    rst     = 1'b1;
    load    = 1'b0;
    bus_gnt = 1'b0;
    #1;
    checkOutput("rw_rst_req", {31'b0, bus_req}, 32'd0);
    checkOutput("rw_rst_stall", {31'b0, stall}, 32'd0);
    checkOutput("rw_rst_rdata", rdata_out, 32'h0);
    checkOutput("rw_rst_wb_en", {31'b0, wb_en}, 32'd0);
    lastRd = 32'h0;
    step();
    rst        = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1111_1111;
    step();
    bus_rvalid = 1'b0;
    checkOutput("rw_late_wb_en", {31'b0, wb_en}, 32'd0);
    checkOutput("rw_late_rdata", rdata_out, 32'h0);
    checkOutput("rw_late_stall", {31'b0, stall}, 32'd0);
    step();
    checkOutput("rw_idle_wb_en", {31'b0, wb_en}, 32'd0);
    runVector('{1'b1, 1'b0, 3'b010, 32'h0000_0800, 32'h0, 32'h2468_ACE0, 4'b1111, 32'h0, 32'h2468_ACE0});

    // Word load at a non-word-aligned address.
`ifdef LSU_MISALIGN_TRAP_EN
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 1'b1, 1'b1, 32'h8765_4321);
    #1;
    checkOutput("mis_idle_stall", {31'b0, stall}, 32'd1);
    checkOutput("mis_idle_req", {31'b0, bus_req}, 32'd0);
    step();
    checkOutput("mis_flag", {31'b0, misalign}, 32'd1);
    checkOutput("mis_req", {31'b0, bus_req}, 32'd0);
    checkOutput("mis_wb_en", {31'b0, wb_en}, 32'd0);
    checkOutput("mis_stall", {31'b0, stall}, 32'd0);
    checkOutput("mis_rdata", rdata_out, lastRd);
    applyStimulus(1'b0, 1'b0, 3'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    checkOutput("mis_clear", {31'b0, misalign}, 32'd0);
    checkOutput("mis_idle_req2", {31'b0, bus_req}, 32'd0);
`else
    runVector('{1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h8765_4321, 4'b1111, 32'h0, 32'h8765_4321});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_sequencer.md
Name: lsu_sequencer

Overview:
- Multi-cycle load/store sequencer between the single-cycle core's decoded control (`load`, `store`, `func3`) and a handshaked data-memory bus.
- Stalls the core while an access is in flight.
- Generates byte lanes and store-data replication, and sign/zero-extends load data.
- Pulses a writeback enable when the load completes.
- Replaces the core's combinational data-memory path. PC and register-file write are gated by `stall` and `wb_en`.

Parameters:
- TIMEOUT, default 255: max cycles spent in REQ+WAIT before abort; 0 disables the timeout.
- CNT_W, default 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load  in  1  decoded load instruction present.
- store  in  1  decoded store instruction present.
- func3  in  3  inst[14:12], access size/sign.
- addr  in  32  effective address from ALU.
- wdata  in  32  rs2 store data.
- bus_req  out  1  request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.
- stall  out  1  hold PC and instruction.
- rdata_out  out  32  extended load result.
- wb_en  out  1  one-cycle register writeback strobe.
- bus_err  out  1  one-cycle timeout abort strobe.
- misalign  out  1  one-cycle misaligned-access strobe.

Behaviour:
- States: IDLE, REQ, WAIT, DONE (2-bit encoding). Reset forces IDLE asynchronously.
- Reset values: all outputs 0, counter 0, capture registers 0.
- IDLE
  - `stall` = load|store, combinational.
  - On load|store: capture addr, func3, wdata and op, then go to REQ.
  - If load and store are both 1, treat as load.
- REQ
  - bus_req=1, stall=1.
  - bus_addr, bus_we, bus_be and bus_wdata come from the captured registers and are stable until bus_gnt.
  - On bus_gnt: store -> DONE (write completes on grant); load -> WAIT.
  - bus_rvalid is ignored in REQ.
- WAIT
  - bus_req=0, stall=1.
  - On bus_rvalid: register the extended data into rdata_out, then go to DONE.
  - rvalid in the same cycle as entry is accepted next cycle only, so minimum load latency is REQ+WAIT.
- DONE
  - stall=0; the core retires the instruction at the end of this cycle.
  - wb_en=1 for a successful load.
  - Always returns to IDLE; the still-asserted load/store is not relaunched.
- Latency with gnt and rvalid immediate:
  - store: 3 cycles stalled-to-retire (IDLE, REQ, DONE).
  - load: 4 cycles (IDLE, REQ, WAIT, DONE).
- Byte enables from func3[1:0]:
  - 00: 4'b0001<<addr[1:0].
  - 01: 4'b0011<<{addr[1],1'b0}.
  - 1x: 4'b1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extraction selects the lane by captured addr[1:0]:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011/110/111: treated as LW.
- rdata_out holds its value until the next load completes.
- Timeout
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When count==TIMEOUT and TIMEOUT!=0: go to DONE with bus_err=1, wb_en=0 and rdata_out unchanged; bus_req drops that cycle.
- Reset mid-access: bus_req and stall deassert immediately; any late bus_gnt or bus_rvalid after reset is ignored in IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access in IDLE goes directly to DONE with misalign=1 and wb_en=0.
  - No bus traffic is issued (bus_req stays 0).
- Not defined
  - misalign is tied 0.
  - The access proceeds with the lane rules above: half ignores addr[0], word ignores addr[1:0].

Test Plan:
- LW, addr=0x1000_0008, gnt immediate, rvalid with rdata=0xDEAD_BEEF the cycle after WAIT entry -> bus_addr=0x1000_0008, be=4'b1111, stall high 3 cycles, DONE: wb_en=1, rdata_out=0xDEAD_BEEF.
- SB, addr=0x203, wdata=0x0000_00A5, gnt delayed 3 cycles -> bus_req held 4 cycles with stable outputs, be=4'b1000, bus_wdata=0xA5A5_A5A5, bus_we=1, no wb_en.
- LB addr=0x101 with rdata=0x0000_8000 -> rdata_out=0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr=0x102 with rdata=0x8001_0000 -> 0xFFFF_8001.
- TIMEOUT=4, load, bus_gnt never asserted -> bus_err=1 in DONE after 5 REQ cycles, wb_en=0, rdata_out unchanged, back to IDLE.
- rst asserted in WAIT, then rvalid pulsed while load=0 -> all outputs 0 immediately, rvalid ignored, state IDLE.
- With LSU_MISALIGN_TRAP_EN, LW addr=0x102 -> misalign=1 in cycle 2, bus_req never asserted. Without the macro -> normal word access to 0x100.
